dds_voice_engine: RTL and testbench

- Parametrised successor of the 4-voice tone-generator core.
- Time-multiplexes NUM_CH DDS phase accumulators, per-channel duty-pulse wave lookup, volume DCA and a saturating mixer through one shared adder.
- Sequenced by the external master sample counter; emits one mixed signed sample per frame with a valid strobe to the audio output stage.
- Adds over the previous core: per-channel wave type, per-channel enable, phase-reset command, true saturation, held output register, reset of all state.

---
 rtl/dds_voice_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_dds_voice_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_voice_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dds_voice_engine
//  Purpose  : Time-multiplexed multi-voice DDS tone generator. NUM_CH phase
//             accumulators share one adder. Each voice has a duty-pulse wave
//             lookup, a volume DCA and a saturating mixer. The engine is
//             sequenced by an external master slot counter and produces one
//             signed mixed sample per frame.
//  Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in           in   1          system clock
//    reset_in         in   1          synchronous active-high reset
//    master_count_in  in   CNT_W      frame slot counter, 0 = frame start
//    data_in          in   ACC_W      register write data
//    addr_in          in   CH_BITS+2  {sel[1:0], ch[CH_BITS-1:0]}
//    data_valid_in    in   1          register write strobe
//    data_out         out  OUT_W      last completed mixed sample (held)
//    data_valid_out   out  1          one-cycle pulse when data_out updates
// ----------------------------------------------------------------------------
//  Slot map (grp = master_count_in >> CH_BITS, ch = low CH_BITS bits)
//    grp 0 : phase update   acc[ch] += incr[ch]  (or cleared if reset pending)
//    grp 1 : wave latch     wav[ch] = duty(acc[ch] top 3 bits, type[ch])
//    grp 2 : mix            running saturating sum of channel contributions
//    grp 3+: idle
// ============================================================================
module dds_voice_engine #(
  parameter int NUM_CH    = 4,
  parameter int ACC_W     = 16,
  parameter int VOL_W     = 8,
  parameter int OUT_W     = 16,
  parameter int MIX_SHIFT = $clog2(NUM_CH),
  parameter int CNT_W     = 10
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [CNT_W-1:0]           master_count_in,
  input  logic [ACC_W-1:0]           data_in,
  input  logic [$clog2(NUM_CH)+1:0]  addr_in,
  input  logic                       data_valid_in,
  output logic [OUT_W-1:0]           data_out,
  output logic                       data_valid_out
);

  localparam int CH_BITS = $clog2(NUM_CH);
  localparam int GRP_W   = CNT_W - CH_BITS;

  localparam logic [1:0] SEL_INCR = 2'd0;
  localparam logic [1:0] SEL_VOL  = 2'd1;
  localparam logic [1:0] SEL_CTRL = 2'd2;

  // --------------------------------------------------------------------------
  // Per-channel state
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]  acc      [NUM_CH];
  logic [ACC_W-1:0]  incr     [NUM_CH];
  logic [VOL_W-1:0]  vol      [NUM_CH];
  logic [1:0]        wtype    [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] rst_pend;
  logic [NUM_CH-1:0] wav;

  // Shared mixer state
  logic [OUT_W-1:0]  mix;
  logic              armed;

  // --------------------------------------------------------------------------
  // Slot decode
  // --------------------------------------------------------------------------
  logic [GRP_W-1:0]   grp;
  logic [CH_BITS-1:0] ch;
  logic               slot_phase;
  logic               slot_latch;
  logic               slot_mix;
  logic               last_ch;

  assign grp        = master_count_in[CNT_W-1:CH_BITS];
  assign ch         = master_count_in[CH_BITS-1:0];
  assign slot_phase = (grp == GRP_W'(0));
  assign slot_latch = (grp == GRP_W'(1));
  assign slot_mix   = (grp == GRP_W'(2));
  assign last_ch    = (ch == CH_BITS'(NUM_CH - 1));

  // --------------------------------------------------------------------------
  // Register write decode
  // --------------------------------------------------------------------------
  logic [1:0]         wr_sel;
  logic [CH_BITS-1:0] wr_ch;

  assign wr_sel = addr_in[CH_BITS+1:CH_BITS];
  assign wr_ch  = addr_in[CH_BITS-1:0];

  // --------------------------------------------------------------------------
  // Duty-pulse wave lookup on the top three phase bits
  // --------------------------------------------------------------------------
  function automatic logic duty_high(input logic [2:0] code, input logic [1:0] t);
    logic h;
    case (t)
      2'd0:    h = code[2];                          // 50.0 %: codes 4-7
      2'd1:    h = &code;                            // 12.5 %: code 7
      2'd2:    h = code[2] & code[1];                // 25.0 %: codes 6-7
      default: h = code[2] & (code[1] | code[0]);    // 37.5 %: codes 5-7
    endcase
    return h;
  endfunction

  logic [2:0] phase_code;
  logic       wav_next;

  assign phase_code = acc[ch][ACC_W-1 -: 3];
  assign wav_next   = duty_high(phase_code, wtype[ch]);

  // --------------------------------------------------------------------------
  // Amplitude: volume bits replicated MSB-first across OUT_W-1 bits so that
  // full-scale volume maps to full-scale positive output. MSB stays zero.
  // --------------------------------------------------------------------------
  logic [VOL_W-1:0] vol_cur;
  logic [OUT_W-1:0] amp;

  assign vol_cur    = vol[ch];
  assign amp[OUT_W-1] = 1'b0;

  for (genvar i = 0; i < OUT_W - 1; i++) begin : g_amp
    assign amp[OUT_W-2-i] = vol_cur[VOL_W-1-(i % VOL_W)];
  end

  // --------------------------------------------------------------------------
  // Channel contribution and saturating accumulate.
  // A low wave uses ~amp, i.e. -(amp+1), so both halves of the pulse span the
  // full signed range symmetrically around -0.5 LSB.
  // --------------------------------------------------------------------------
  logic [OUT_W-1:0] c_raw;
  logic [OUT_W-1:0] c_shifted;
  logic [OUT_W-1:0] contrib;
  logic [OUT_W-1:0] prev;
  logic [OUT_W:0]   sum_ext;
  logic [OUT_W-1:0] sum_sat;

  assign c_raw     = wav[ch] ? amp : ~amp;
  assign c_shifted = $signed(c_raw) >>> MIX_SHIFT;
  assign contrib   = en[ch] ? c_shifted : '0;

  // Channel 0 starts a fresh sum; the stale value from last frame is ignored.
  assign prev      = (ch == '0) ? '0 : mix;
  assign sum_ext   = {prev[OUT_W-1], prev} + {contrib[OUT_W-1], contrib};

  // Overflow shows up as disagreement between the extended sign and the
  // OUT_W-bit sign; the extended sign tells which rail to clamp to.
  always_comb begin
    sum_sat = sum_ext[OUT_W-1:0];
    if (sum_ext[OUT_W] != sum_ext[OUT_W-1]) begin
      sum_sat = sum_ext[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  // --------------------------------------------------------------------------
  // Phase accumulators, reset-pending flags and channel configuration.
  // Non-blocking semantics give the collision rule for free: a write landing
  // in the same cycle as a channel's slot is seen from the next frame on.
  // A reset-pending set by a write wins over the clear done by the slot.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        incr[i]  <= '0;
        vol[i]   <= '0;
        wtype[i] <= '0;
      end
      en       <= '0;
      rst_pend <= '0;
    end else begin
      if (slot_phase) begin
        if (rst_pend[ch]) begin
          acc[ch]      <= '0;
          rst_pend[ch] <= 1'b0;
        end else begin
          acc[ch] <= acc[ch] + incr[ch];
        end
      end

      if (data_valid_in) begin
        case (wr_sel)
          SEL_INCR: incr[wr_ch] <= data_in;
          SEL_VOL:  vol[wr_ch]  <= data_in[VOL_W-1:0];
          SEL_CTRL: begin
            wtype[wr_ch] <= data_in[1:0];
            en[wr_ch]    <= data_in[2];
            if (data_in[3]) begin
              rst_pend[wr_ch] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Wave latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wav <= '0;
    end else if (slot_latch) begin
      wav[ch] <= wav_next;
    end
  end

  // --------------------------------------------------------------------------
  // Mixer, arming and output register.
  // After reset the engine stays unarmed until the next frame start so a
  // partially mixed frame is never presented.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mix            <= '0;
      armed          <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;

      if (master_count_in == '0) begin
        armed <= 1'b1;
      end

      if (slot_mix) begin
        mix <= sum_sat;
        if (last_ch && armed) begin
          data_out       <= sum_sat;
          data_valid_out <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_voice_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_voice_engine
//  Purpose  : Self-checking bench for dds_voice_engine. Two instances share
//             all stimulus: one with the default mix shift, one with no shift
//             so saturation is exercised. A frame-rule model predicts the
//             outputs of both every cycle; literal checks pin key samples.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_voice_engine;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 16;
  localparam int VOL_W  = 8;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  din;
  logic [3:0]        addr;
  logic              dv;
  logic [OUT_W-1:0]  out_a;
  logic [OUT_W-1:0]  out_b;
  logic              vld_a;
  logic              vld_b;

  always #5 clk = ~clk;

  dds_voice_engine #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) u_dut_a (
    .clk_in(clk), .reset_in(rst), .master_count_in(cnt), .data_in(din),
    .addr_in(addr), .data_valid_in(dv), .data_out(out_a), .data_valid_out(vld_a)
  );

  dds_voice_engine #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .VOL_W(VOL_W), .OUT_W(OUT_W),
    .MIX_SHIFT(0), .CNT_W(CNT_W)
  ) u_dut_b (
    .clk_in(clk), .reset_in(rst), .master_count_in(cnt), .data_in(din),
    .addr_in(addr), .data_valid_in(dv), .data_out(out_b), .data_valid_out(vld_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t cnt=%h)", name, act, exp, $time, cnt);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: integer arithmetic on the documented slot rules.
  // Index k selects the instance: k=0 shift 2, k=1 shift 0.
  // --------------------------------------------------------------------------
  int m_acc [NUM_CH];
  int m_incr[NUM_CH];
  int m_vol [NUM_CH];
  int m_type[NUM_CH];
  bit m_en  [NUM_CH];
  bit m_pend[NUM_CH];
  bit m_wav [NUM_CH];
  int m_mix [2];
  int exp_out[2];
  bit exp_vld;
  bit m_armed;

  // 8-bit volume replicated over 15 bits: v followed by its top 7 bits.
  function automatic int amp_of(int v);
    return ((v << 7) | (v >> 1)) & 32'h7FFF;
  endfunction

  function automatic bit is_high(int code, int t);
    int thr;
    case (t)
      0:       thr = 4;
      1:       thr = 7;
      2:       thr = 6;
      default: thr = 5;
    endcase
    return code >= thr;
  endfunction

  function automatic int contrib_of(int k, int c);
    int a;
    int v;
    if (!m_en[c]) return 0;
    a = amp_of(m_vol[c]);
    v = m_wav[c] ? a : -a - 1;
    return (k == 0) ? (v >>> 2) : v;
  endfunction

  function automatic int sat(int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [15:0] e16(int k);
    int v;
    v = exp_out[k];
    return v[15:0];
  endfunction

  always @(posedge clk) begin : model
    int g;
    int c;
    int sel;
    int wc;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] = 0; m_incr[i] = 0; m_vol[i] = 0; m_type[i] = 0;
        m_en[i] = 0; m_pend[i] = 0; m_wav[i] = 0;
      end
      m_mix[0] = 0; m_mix[1] = 0;
      exp_out[0] = 0; exp_out[1] = 0;
      exp_vld = 0; m_armed = 0;
    end else begin
      g = int'(cnt) / NUM_CH;
      c = int'(cnt) % NUM_CH;
      exp_vld = 0;
      if (g == 0) begin
        if (m_pend[c]) begin
          m_acc[c]  = 0;
          m_pend[c] = 0;
        end else begin
          m_acc[c] = (m_acc[c] + m_incr[c]) % 65536;
        end
      end
      if (g == 1) m_wav[c] = is_high(m_acc[c] / 8192, m_type[c]);
      if (g == 2) begin
        for (int k = 0; k < 2; k++) begin
          m_mix[k] = sat(((c == 0) ? 0 : m_mix[k]) + contrib_of(k, c));
          if (c == NUM_CH - 1 && m_armed) exp_out[k] = m_mix[k];
        end
        if (c == NUM_CH - 1 && m_armed) exp_vld = 1;
      end
      if (cnt == 0) m_armed = 1;
      if (dv) begin
        sel = int'(addr) / NUM_CH;
        wc  = int'(addr) % NUM_CH;
        case (sel)
          0: m_incr[wc] = int'(din);
          1: m_vol[wc]  = int'(din) % 256;
          2: begin
            m_type[wc] = int'(din) % 4;
            m_en[wc]   = din[2];
            if (din[3]) m_pend[wc] = 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_valid_a", {15'd0, vld_a}, {15'd0, exp_vld});
      chk("cyc_valid_b", {15'd0, vld_b}, {15'd0, exp_vld});
      chk("cyc_out_a", out_a, e16(0));
      chk("cyc_out_b", out_b, e16(1));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
    cnt = cnt + 1'b1;
  endtask

  task automatic wr(input int sel, input int ch, input int data);
    addr = 4'((sel << 2) | ch);
    din  = 16'(data);
    dv   = 1'b1;
    cyc();
    dv   = 1'b0;
  endtask

  task automatic wait_count(input int v);
    int n;
    n = 0;
    while (cnt != CNT_W'(v) && n < 2048) begin
      cyc();
      n++;
    end
    if (cnt != CNT_W'(v)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_count: got %h expected %h", cnt, v);
    end
  endtask

  // Advance to the sample of the next frame and check it at the negedge.
  task automatic frame_chk(input string name, input logic [15:0] ea, input logic [15:0] eb, input bit use_b);
    wait_count(0);
    wait_count(12);
    @(negedge clk);
    chk({name, "_vld"}, {15'd0, vld_a}, 16'd1);
    chk({name, "_a"}, out_a, ea);
    chk({name, "_model"}, e16(0), ea);
    if (use_b) chk({name, "_b"}, out_b, eb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    cnt  = 10'h3F0;
    din  = '0;
    addr = '0;
    dv   = 1'b0;
    cyc();
    checking = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("reset_out", out_a, 16'h0000);
    chk("reset_vld", {15'd0, vld_a}, 16'd0);
    cyc();
    rst = 1'b0;

    // All voices: full volume, 50% duty, enabled, phase static at 0.
    for (int c = 0; c < NUM_CH; c++) begin
      wr(1, c, 16'h00FF);
      wr(2, c, 16'h0004);
    end
    wr(3, 0, 16'hFFFF);
    frame_chk("all_low", 16'h8000, 16'h8000, 1'b1);

    // ch0 toggles every frame.
    wr(0, 0, 16'h8000);
    frame_chk("ch0_high", 16'hBFFF, 16'h8000, 1'b1);
    frame_chk("ch0_wrap", 16'h8000, 16'h8000, 1'b1);

    // All four high: unshifted instance saturates positive.
    for (int c = 1; c < NUM_CH; c++) wr(0, c, 16'h8000);
    frame_chk("all_high", 16'h7FFC, 16'h7FFF, 1'b1);
    frame_chk("all_low2", 16'h8000, 16'h8000, 1'b1);
    for (int c = 0; c < NUM_CH; c++) wr(0, c, 16'h0000);

    // Phase-reset command on ch1.
    wr(0, 1, 16'h4000);
    frame_chk("ch1_4000", 16'h8000, 16'h8000, 1'b0);
    frame_chk("ch1_8000", 16'hBFFF, 16'h8000, 1'b0);
    wr(2, 1, 16'h000C);
    frame_chk("ch1_reset", 16'h8000, 16'h8000, 1'b0);
    frame_chk("ch1_after", 16'h8000, 16'h8000, 1'b0);
    frame_chk("ch1_again", 16'hBFFF, 16'h8000, 1'b0);
    wr(0, 1, 16'h0000);
    wr(2, 1, 16'h000C);
    frame_chk("ch1_stop", 16'h8000, 16'h8000, 1'b0);

    // Increment collision at count 0, with 12.5% duty on ch0.
    wr(2, 0, 16'h0005);
    wr(0, 0, 16'h7000);
    frame_chk("ch0_7000", 16'h8000, 16'h8000, 1'b0);
    wait_count(0);
    wr(0, 0, 16'h1000);
    wait_count(12);
    @(negedge clk);
    chk("collide_a", out_a, 16'hBFFF);
    frame_chk("ch0_F000", 16'hBFFF, 16'h8000, 1'b0);
    frame_chk("ch0_0000", 16'h8000, 16'h8000, 1'b0);
    wr(0, 0, 16'hD000);
    frame_chk("ch0_code6", 16'h8000, 16'h8000, 1'b0);

    // Reset mid-frame: no partial sample, then a clean all-zero frame.
    wait_count(9);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_count(12);
    @(negedge clk);
    chk("midrst_vld", {15'd0, vld_a}, 16'd0);
    chk("midrst_out", out_a, 16'h0000);
    frame_chk("post_rst", 16'h0000, 16'h0000, 1'b1);
    cyc();
    @(negedge clk);
    chk("pulse_width", {15'd0, vld_a}, 16'd0);

    // Cleared increment keeps ch0 at phase 0 once re-enabled.
    wr(1, 0, 16'h00FF);
    wr(2, 0, 16'h0004);
    frame_chk("rst_cleared", 16'hE000, 16'h8000, 1'b1);

    cyc();
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
